// File: rtl/cfg_write_arbiter_pkg.sv
// Shared constants, register defaults and FSM encoding for the config write arbiter.
package cfg_pkg;

    localparam int NUM_REGS = 5;
    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 8;

    localparam int ADDR_EN_OUT_LO = 0;
    localparam int ADDR_EN_OUT_HI = 1;
    localparam int ADDR_EN_PWM_LO = 2;
    localparam int ADDR_EN_PWM_HI = 3;
    localparam int ADDR_PWM_DUTY  = 4;

    localparam logic [DATA_W-1:0] REG_DEFAULT [NUM_REGS] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h80};

    typedef enum logic [1:0] {INIT, IDLE, COMMIT} state_t;

endpackage

// File: rtl/cfg_write_arbiter_if.sv
// Two-requester write bus; requesters sit on the master side, the arbiter on the slave side.
interface cfg_write_arbiter_if #(
    parameter int ADDR_W = cfg_pkg::ADDR_W,
    parameter int DATA_W = cfg_pkg::DATA_W
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/cfg_write_arbiter_rr_arb2.sv
// Two-way round-robin picker: combinational grant, registered last_grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       only_other,
    input  logic       take,
    output logic       gnt_any,
    output logic       gnt_idx,
    output logic       last_grant
);
    logic [1:0] elig;

    // While a commit is in flight only the requester not currently granted may follow it.
    assign elig    = only_other ? (req & (last_grant ? 2'b01 : 2'b10)) : req;
    assign gnt_any = |elig;
    assign gnt_idx = (&elig) ? ~last_grant : elig[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant <= 1'b1;
        else if (take && gnt_any)
            last_grant <= gnt_idx;
    end
endmodule

// File: rtl/cfg_write_arbiter.sv
// Config register bank with power-up default load and two-requester round-robin write arbitration.
module cfg_write_arbiter
    import cfg_pkg::*;
#(
    parameter int NUM_REGS = cfg_pkg::NUM_REGS,
    parameter int ADDR_W   = cfg_pkg::ADDR_W,
    parameter int DATA_W   = cfg_pkg::DATA_W,
    parameter bit INIT_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    cfg_write_arbiter_if.slave bus,
    output logic [DATA_W-1:0] en_reg_out_7_0,
    output logic [DATA_W-1:0] en_reg_out_15_8,
    output logic [DATA_W-1:0] en_reg_pwm_7_0,
    output logic [DATA_W-1:0] en_reg_pwm_15_8,
    output logic [DATA_W-1:0] pwm_duty_cycle,
    output logic              err_addr,
    output logic              init_busy
);
    localparam int     CNT_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam state_t RST_STATE = INIT_EN ? INIT : IDLE;

    state_t                         state, state_nxt;
    logic [CNT_W-1:0]               init_cnt;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [ADDR_W-1:0]              hold_addr;
    logic [DATA_W-1:0]              hold_data;
    logic [1:0]                     arb_req;
    logic                           arb_only_other, arb_take, arb_any, arb_idx, last_grant;

    // Requests are masked during INIT so they wait, still asserted, until IDLE.
    assign arb_req        = (state == INIT) ? 2'b00 : {bus.req1_valid, bus.req0_valid};
    assign arb_only_other = (state == COMMIT);

    rr_arb2 u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (arb_req),
        .only_other (arb_only_other),
        .take       (arb_take),
        .gnt_any    (arb_any),
        .gnt_idx    (arb_idx),
        .last_grant (last_grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RST_STATE;
            init_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT)
                init_cnt <= init_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        arb_take  = 1'b0;
        unique case (state)
            INIT: begin
                if (init_cnt == CNT_W'(NUM_REGS - 1))
                    state_nxt = IDLE;
            end
            IDLE, COMMIT: begin
                if (arb_any) begin
                    state_nxt = COMMIT;
                    arb_take  = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_addr <= '0;
            hold_data <= '0;
        end else if (arb_take) begin
            hold_addr <= arb_idx ? bus.req1_addr : bus.req0_addr;
            hold_data <= arb_idx ? bus.req1_data : bus.req0_data;
        end
    end

    // In COMMIT, last_grant already names the requester being served this cycle.
    assign bus.req0_ready = (state == COMMIT) && !last_grant;
    assign bus.req1_ready = (state == COMMIT) &&  last_grant;
    assign err_addr       = (state == COMMIT) && (hold_addr >= ADDR_W'(NUM_REGS));
    assign init_busy      = (state == INIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (state == INIT && init_cnt == CNT_W'(k))
                    regs[k] <= REG_DEFAULT[k];
                else if (state == COMMIT && hold_addr == ADDR_W'(k))
                    regs[k] <= hold_data;
            end
        end
    end

    assign en_reg_out_7_0  = regs[ADDR_EN_OUT_LO];
    assign en_reg_out_15_8 = regs[ADDR_EN_OUT_HI];
    assign en_reg_pwm_7_0  = regs[ADDR_EN_PWM_LO];
    assign en_reg_pwm_15_8 = regs[ADDR_EN_PWM_HI];
    assign pwm_duty_cycle  = regs[ADDR_PWM_DUTY];
endmodule

// File: tb/tb_cfg_write_arbiter.sv
// Directed scenarios plus random two-requester traffic checked against a register-array scoreboard.
module tb_cfg_write_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] o_out_lo, o_out_hi, o_pwm_lo, o_pwm_hi, o_duty;
    logic       err_addr, init_busy;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] mdl [5];
    logic [7:0] dflt [5];

    always #5 clk = ~clk;

    cfg_write_arbiter_if bus ();

    cfg_write_arbiter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .en_reg_out_7_0  (o_out_lo),
        .en_reg_out_15_8 (o_out_hi),
        .en_reg_pwm_7_0  (o_pwm_lo),
        .en_reg_pwm_15_8 (o_pwm_hi),
        .pwm_duty_cycle  (o_duty),
        .err_addr        (err_addr),
        .init_busy       (init_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] dut_reg(input int k);
        case (k)
            0:       return o_out_lo;
            1:       return o_out_hi;
            2:       return o_pwm_lo;
            3:       return o_pwm_hi;
            default: return o_duty;
        endcase
    endfunction

    task automatic chk_regs(input string tag);
        for (int k = 0; k < 5; k++)
            chk($sformatf("%s_r%0d", tag, k), dut_reg(k), mdl[k]);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drive(input int r, input logic v, input logic [6:0] a, input logic [7:0] d);
        if (r == 0) begin
            bus.req0_valid = v; bus.req0_addr = a; bus.req0_data = d;
        end else begin
            bus.req1_valid = v; bus.req1_addr = a; bus.req1_data = d;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d0 [4];
        logic [7:0] d1 [4];
        int         grants [$];
        int         gcyc [$];
        int         i0, i1;
        logic       a0, a1;
        logic       v [2];
        logic [6:0] ra [2];
        logic [7:0] rd [2];
        int         wt [2];
        logic       acc [2];
        logic [1:0] rdy;

        dflt = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
        rst_n = 1'b0;
        drive(0, 1'b0, 7'd0, 8'd0);
        drive(1, 1'b0, 7'd0, 8'd0);
        for (int k = 0; k < 5; k++) mdl[k] = 8'h00;

        // reset state and init sequence
        repeat (2) @(posedge clk);
        smp();
        chk_regs("rst");
        chk("rst_rdy0", bus.req0_ready, 0);
        chk("rst_rdy1", bus.req1_ready, 0);
        chk("rst_err", err_addr, 0);
        chk("rst_busy", init_busy, 1);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            smp();
            chk($sformatf("init_busy%0d", i), init_busy, 1);
            chk($sformatf("init_duty%0d", i), o_duty, 8'h00);
            chk($sformatf("init_rdy%0d", i), {bus.req1_ready, bus.req0_ready}, 0);
        end
        smp();
        mdl = dflt;
        chk_regs("init_done");
        chk("init_busy_fall", init_busy, 0);

        // first tie goes to requester 0, requester 1 follows next cycle
        step();
        drive(0, 1'b1, 7'd0, 8'h11);
        drive(1, 1'b1, 7'd1, 8'h22);
        smp();
        chk("tie_idle_rdy", {bus.req1_ready, bus.req0_ready}, 2'b00);
        smp();
        chk("tie_first", {bus.req1_ready, bus.req0_ready}, 2'b01);
        step();
        drive(0, 1'b0, 7'd0, 8'h00);
        smp();
        chk("tie_second", {bus.req1_ready, bus.req0_ready}, 2'b10);
        mdl[0] = 8'h11;
        chk_regs("tie_w0");
        step();
        drive(1, 1'b0, 7'd0, 8'h00);
        smp();
        chk("tie_done_rdy", {bus.req1_ready, bus.req0_ready}, 2'b00);
        mdl[1] = 8'h22;
        chk_regs("tie_w1");

        // both stream four writes to addr 4: strict alternation, one write per cycle
        for (int i = 0; i < 4; i++) begin
            d0[i] = 8'($urandom_range(0, 255)); if (d0[i] == 8'h33) d0[i] = 8'h34;
            d1[i] = 8'($urandom_range(0, 255)); if (d1[i] == 8'h33) d1[i] = 8'h34;
        end
        i0 = 0; i1 = 0;
        step();
        drive(0, 1'b1, 7'd4, d0[0]);
        drive(1, 1'b1, 7'd4, d1[0]);
        for (int c = 0; c < 20; c++) begin
            smp();
            a0 = bus.req0_ready;
            a1 = bus.req1_ready;
            if (a0) begin grants.push_back(0); gcyc.push_back(c); end
            if (a1) begin grants.push_back(1); gcyc.push_back(c); end
            step();
            if (a0) i0++;
            if (a1) i1++;
            drive(0, i0 < 4, 7'd4, d0[(i0 < 4) ? i0 : 3]);
            drive(1, i1 < 4, 7'd4, d1[(i1 < 4) ? i1 : 3]);
            if (i0 == 4 && i1 == 4) break;
        end
        chk("stream_count", grants.size(), 8);
        if (grants.size() == 8) begin
            for (int j = 0; j < 8; j++)
                chk($sformatf("stream_g%0d", j), grants[j], j % 2);
            chk("stream_span", gcyc[7] - gcyc[0], 7);
        end
        smp();
        mdl[4] = d1[3];
        chk_regs("stream_final");

        // single write, two-cycle latency
        step();
        drive(0, 1'b1, 7'd2, 8'hA5);
        smp();
        chk("w2_rdy_c0", bus.req0_ready, 0);
        smp();
        chk("w2_rdy_c1", bus.req0_ready, 1);
        chk_regs("w2_pre");
        step();
        drive(0, 1'b0, 7'd0, 8'h00);
        smp();
        chk("w2_rdy_c2", bus.req0_ready, 0);
        mdl[2] = 8'hA5;
        chk_regs("w2_post");

        // out-of-range address
        step();
        drive(1, 1'b1, 7'd7, 8'hFF);
        smp();
        smp();
        chk("bad_rdy", bus.req1_ready, 1);
        chk("bad_err", err_addr, 1);
        step();
        drive(1, 1'b0, 7'd0, 8'h00);
        smp();
        chk("bad_err_fall", err_addr, 0);
        chk("bad_rdy_fall", bus.req1_ready, 0);
        chk_regs("bad_regs");

        // reset during a commit aborts the write
        step();
        drive(0, 1'b1, 7'd4, 8'h33);
        smp();
        smp();
        chk("rstc_rdy", bus.req0_ready, 1);
        rst_n = 1'b0;
        #1;
        chk("rstc_duty0", o_duty, 8'h00);
        chk("rstc_rdy0", bus.req0_ready, 0);
        chk("rstc_busy", init_busy, 1);
        drive(0, 1'b0, 7'd0, 8'h00);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            smp();
            chk($sformatf("rstc_no33_%0d", i), o_duty == 8'h33, 0);
            chk($sformatf("rstc_busy%0d", i), init_busy, 1);
        end
        smp();
        chk("rstc_duty80", o_duty, 8'h80);
        chk("rstc_busy_fall", init_busy, 0);
        mdl = dflt;
        chk_regs("rstc_regs");

        // random traffic against the scoreboard
        for (int r = 0; r < 2; r++) begin
            v[r] = 1'b0; ra[r] = '0; rd[r] = '0; wt[r] = 0; acc[r] = 1'b0;
        end
        for (int c = 0; c < 400; c++) begin
            step();
            for (int r = 0; r < 2; r++) begin
                if (acc[r] && ra[r] < 7'd5) mdl[ra[r]] = rd[r];
                if (acc[r] || !v[r]) begin
                    v[r]  = ($urandom_range(0, 3) != 0);
                    ra[r] = 7'($urandom_range(0, 7));
                    rd[r] = 8'($urandom_range(0, 255));
                    wt[r] = 0;
                end
                drive(r, v[r], ra[r], rd[r]);
            end
            smp();
            chk_regs("rnd");
            rdy = {bus.req1_ready, bus.req0_ready};
            chk("rnd_one_rdy", &rdy, 0);
            chk("rnd_err", err_addr,
                (rdy[0] && ra[0] >= 7'd5) || (rdy[1] && ra[1] >= 7'd5));
            for (int r = 0; r < 2; r++) begin
                acc[r] = rdy[r];
                if (rdy[r]) begin
                    chk($sformatf("rnd_rdy_vld%0d", r), v[r], 1);
                    chk($sformatf("rnd_lat%0d", r), wt[r] <= 2, 1);
                end else if (v[r]) begin
                    wt[r]++;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
